// File: rtl/spi_to_frame_buffer.sv
// Purpose: SPI host byte stream -> raster-order frame buffer writes, then one JPEG encoder start per frame.
// Latency: a byte accepted on cycle N is written (fb_we/fb_addr/fb_data) on cycle N+1; all outputs registered.
// Backpressure: none; bytes arriving while the encoder owns the frame are dropped and flag frame_err.
// Optional: define FRAME_CKSUM_EN to require a 16-bit byte-sum trailer (MSB first) before starting the encoder.
module spi_to_frame_buffer #(
  parameter int          WIDTH     = 320,
  parameter int          HEIGHT    = 200,
  parameter int          BPP       = 2,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_wr,
  input  logic [7:0]  spi_wdata,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        je_start,
  input  logic        je_done,
  output logic        busy,
  output logic        frame_err,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y
);

  localparam int BI_W = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC1,
    RX_PIX,
    START,
    WAIT_ENC
`ifdef FRAME_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  state_t          state, next_state;
  logic [BI_W-1:0] byte_idx;
  logic            acc_pix;    // pixel byte accepted this cycle
  logic            sync_ok;    // preamble completed this cycle
  logic            overrun;    // byte arrived while encoder owns the frame
  logic            ck_bad;     // trailer did not match the running sum
  logic            last_pix;   // counters point at the final byte of the frame
  logic [16:0]     pix_addr;

`ifdef FRAME_CKSUM_EN
  logic [15:0] ck_sum;
  logic        ck_phase;
  logic [7:0]  ck_msb;
`endif

  // Raster byte address of the current counter position, kept in 17 bits
  assign pix_addr = (17'(pix_y) * 17'(WIDTH) + 17'(pix_x)) * 17'(BPP) + 17'(byte_idx);
  assign last_pix = (byte_idx == BI_W'(BPP - 1)) && (pix_x == 9'(WIDTH - 1)) &&
                    (pix_y == 8'(HEIGHT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode and per-cycle event strobes
  always_comb begin
    next_state = state;
    acc_pix    = 1'b0;
    sync_ok    = 1'b0;
    overrun    = 1'b0;
    ck_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (spi_wr && spi_wdata == SYNC_WORD[15:8]) next_state = SYNC1;
      end
      SYNC1: begin
        if (spi_wr) begin
          if (spi_wdata == SYNC_WORD[7:0]) begin
            next_state = RX_PIX;
            sync_ok    = 1'b1;
          end else if (spi_wdata == SYNC_WORD[15:8]) begin
            next_state = SYNC1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      RX_PIX: begin
        if (spi_wr) begin
          acc_pix = 1'b1;
`ifdef FRAME_CKSUM_EN
          if (last_pix) next_state = CKSUM;
`else
          if (last_pix) next_state = START;
`endif
        end
      end
      START: begin
        overrun    = spi_wr;
        next_state = WAIT_ENC;
      end
      WAIT_ENC: begin
        overrun = spi_wr;
        if (je_done) next_state = IDLE;
      end
`ifdef FRAME_CKSUM_EN
      CKSUM: begin
        if (spi_wr && ck_phase) begin
          if ({ck_msb, spi_wdata} == ck_sum) begin
            next_state = START;
          end else begin
            next_state = IDLE;
            ck_bad     = 1'b1;
          end
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Pixel position counters: cleared on sync, advanced per accepted byte, frozen after the last byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else if (sync_ok) begin
      byte_idx <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else if (acc_pix && !last_pix) begin
      if (byte_idx == BI_W'(BPP - 1)) begin
        byte_idx <= '0;
        if (pix_x == 9'(WIDTH - 1)) begin
          pix_x <= '0;
          pix_y <= pix_y + 8'd1;
        end else begin
          pix_x <= pix_x + 9'd1;
        end
      end else begin
        byte_idx <= byte_idx + BI_W'(1);
      end
    end
  end

  // Registered frame buffer write port and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      je_start  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fb_we    <= acc_pix;
      je_start <= (state == START);
      busy     <= (next_state != IDLE);
      if (acc_pix) begin
        fb_addr <= pix_addr;
        fb_data <= spi_wdata;
      end
      if (sync_ok)                frame_err <= 1'b0;
      else if (overrun || ck_bad) frame_err <= 1'b1;
    end
  end

`ifdef FRAME_CKSUM_EN
  // Running byte sum over pixel data and two-byte trailer capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_sum   <= '0;
      ck_phase <= 1'b0;
      ck_msb   <= '0;
    end else if (sync_ok) begin
      ck_sum   <= '0;
      ck_phase <= 1'b0;
    end else begin
      if (acc_pix) ck_sum <= ck_sum + 16'(spi_wdata);
      if (state == CKSUM && spi_wr) begin
        ck_phase <= ~ck_phase;
        if (!ck_phase) ck_msb <= spi_wdata;
      end
    end
  end
`endif

endmodule
